// File: rtl/adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// The default operand width lives here so users and the adder agree on it.
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 4;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder: the combinational cell chained by adder_4bit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/adder_4bit.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin, one cycle of latency.
// Define ADDER_4BIT_OVF_EN to add the registered two's-complement overflow output ovf.
module adder_4bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_4BIT_OVF_EN
  ,
  output logic             ovf
`endif
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry-out of the whole chain.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign c[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (c[gi]),
      .s    (sum_d[gi]),
      .cout (c[gi+1])
    );
  end

`ifdef ADDER_4BIT_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= c[WIDTH];
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= c[WIDTH];
    end
  end
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : adder_4bit

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit: directed, reset, exhaustive and random vectors
// against an arithmetic reference model (ovf is checked when ADDER_4BIT_OVF_EN is set).
module tb_adder_4bit;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDER_4BIT_OVF_EN
  logic         ovf;
`endif

  int n_cmp;
  int n_err;

  adder_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
`ifdef ADDER_4BIT_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  task automatic check_result(input int va, input int vb, input int vc);
    int total;
    int sa;
    int sb;
    int ssum;
    logic [31:0] exp_sum;
    logic [31:0] exp_cout;
    logic [31:0] exp_ovf;
    total    = va + vb + vc;
    exp_sum  = total % (2 ** W);
    exp_cout = total / (2 ** W);
    sa       = (va >= 2 ** (W - 1)) ? va - 2 ** W : va;
    sb       = (vb >= 2 ** (W - 1)) ? vb - 2 ** W : vb;
    ssum     = sa + sb + vc;
    exp_ovf  = (ssum > 2 ** (W - 1) - 1 || ssum < -(2 ** (W - 1))) ? 1 : 0;
    $display("txn a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d (exp %0h/%0d ovf %0d)",
             va, vb, vc, sum, cout, exp_sum, exp_cout, exp_ovf);
    check("sum", 32'(sum), exp_sum);
    check("cout", 32'(cout), exp_cout);
`ifdef ADDER_4BIT_OVF_EN
    check("ovf", 32'(ovf), exp_ovf);
`endif
  endtask

  task automatic drive(input int va, input int vb, input int vc);
    a   = W'(va);
    b   = W'(vb);
    cin = vc[0];
  endtask

  task automatic run_vec(input int va, input int vb, input int vc);
    @(negedge clk);
    drive(va, vb, vc);
    @(posedge clk);
    #1;
    check_result(va, vb, vc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sum"}, 32'(sum), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'd0);
`ifdef ADDER_4BIT_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  int dir_tab [11][3] = '{
    '{ 0,  0, 1},
    '{ 3,  6, 1},
    '{ 2,  8, 0},
    '{15,  4, 0},
    '{12, 14, 0},
    '{15,  0, 1},
    '{15, 15, 1},
    '{ 7,  1, 0},
    '{ 8, 15, 0},
    '{ 3,  4, 0},
    '{ 8,  8, 0}
  };

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset asserted from time 0 with busy inputs: outputs zero before any edge.
    rst_n = 1'b0;
    drive(15, 15, 1);
    #2;
    check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_hold");

    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir_tab[i]) run_vec(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2]);

    // Input changes between edges must not reach the registered outputs.
    @(negedge clk);
    drive(9, 9, 1);
    #2;
    check_result(8, 8, 0);
    @(posedge clk);
    #1;
    check_result(9, 9, 1);

    // Mid-stream reset clears at once and discards the in-flight vector.
    @(negedge clk);
    drive(5, 6, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(posedge clk);
    #1;
    check_zero("rst_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    drive(10, 3, 1);
    @(posedge clk);
    #1;
    check_result(10, 3, 1);

    for (int va = 0; va < 2 ** W; va++)
      for (int vb = 0; vb < 2 ** W; vb++)
        for (int vc = 0; vc < 2; vc++)
          run_vec(va, vb, vc);

    for (int i = 0; i < 200; i++)
      run_vec(int'($urandom_range(2 ** W - 1)), int'($urandom_range(2 ** W - 1)),
              int'($urandom_range(1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_adder_4bit
